// File: rtl/srlvec_fifo.sv
// srlvec_fifo: first-word-fall-through FIFO on a per-bit SRL shift register
// (srlvec), with an occupancy counter and a registered output stage.
module srlvec #(
    parameter int NBITS = 8,
    parameter USE_SRL16 = "TRUE",
    localparam int DEPTH = (USE_SRL16 == "TRUE") ? 16 : 32,
    localparam int ADDR_BITS = (USE_SRL16 == "TRUE") ? 4 : 5
) (
    input  logic                 clk,
    input  logic                 ce,
    input  logic [ADDR_BITS-1:0] a,
    input  logic [NBITS-1:0]     din,
    output logic [NBITS-1:0]     dout
);
    logic [DEPTH-1:0][NBITS-1:0] sr_q, sr_d;
    always_comb sr_d = ce ? {sr_q[DEPTH-2:0], din} : sr_q;
    always_ff @(posedge clk) sr_q <= sr_d;
    assign dout = sr_q[a];
endmodule

module srlvec_fifo #(
    parameter int NBITS = 8,
    parameter USE_SRL16 = "TRUE",
    localparam int DEPTH = (USE_SRL16 == "TRUE") ? 16 : 32,
    localparam int ADDR_BITS = (USE_SRL16 == "TRUE") ? 4 : 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBITS-1:0]     s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [NBITS-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ADDR_BITS+1:0] count
);
    localparam logic [ADDR_BITS:0] CNT_FULL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] A_ONE = ADDR_BITS'(1);
    logic [ADDR_BITS:0]   srl_cnt_q, srl_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [NBITS-1:0]     m_data_q, m_data_d, srl_dout;
    logic [ADDR_BITS-1:0] srl_a;
    logic                 wr, load;
    srlvec #(.NBITS(NBITS), .USE_SRL16(USE_SRL16)) u_srl (
        .clk (clk),
        .ce  (wr),
        .a   (srl_a),
        .din (s_data),
        .dout(srl_dout)
    );
    // Oldest word sits at srl_cnt-1; the output register pulls it whenever it is empty or draining.
    always_comb begin
        s_ready   = !rst && (srl_cnt_q != CNT_FULL);
        wr        = s_valid && s_ready;
        load      = (srl_cnt_q != '0) && (!m_valid_q || m_ready);
        srl_a     = srl_cnt_q[ADDR_BITS-1:0] - A_ONE;
        srl_cnt_d = (wr && !load) ? srl_cnt_q + CNT_ONE :
                    (load && !wr) ? srl_cnt_q - CNT_ONE : srl_cnt_q;
        m_valid_d = load || (m_valid_q && !(m_ready && srl_cnt_q == '0));
        m_data_d  = load ? srl_dout : m_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            srl_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            srl_cnt_q <= srl_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign count   = {1'b0, srl_cnt_q} + {{(ADDR_BITS+1){1'b0}}, m_valid_q};
endmodule
